// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SSD1306-subset SPI responder feeding a 4x128 byte framebuffer write port.
// Optional build macro OLED_SINK_CS_EN enables chip-select framing and the frame_err flag.
`default_nettype none

module oled_spi_sink #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       SDIN,
    input  logic       DC,
    input  logic       CS,
    input  logic       err_clr,
    output logic       fb_we,
    output logic [8:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       disp_on,
    output logic       entire_on,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [1:0] CMD      = 2'd0;
    localparam logic [1:0] ARG_PS   = 2'd1;
    localparam logic [1:0] ARG_PE   = 2'd2;
    localparam logic [1:0] ARG_SKIP = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sclk_q;
    logic                   sdin_q;
    logic                   dc_q;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic                   shift_en;

    // SCLK idles high, so its synchroniser resets high to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '1;
            sdin_sync <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], SDIN};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
            sclk_prev <= sclk_q;
        end
    end

    assign sclk_q    = sclk_sync[SYNC_STAGES-1];
    assign sdin_q    = sdin_sync[SYNC_STAGES-1];
    assign dc_q      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_q & ~sclk_prev;

`ifdef OLED_SINK_CS_EN
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_q;
    logic                   cs_prev;
    logic                   cs_rise;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_sync <= '1;
            cs_prev <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS};
            cs_prev <= cs_q;
        end
    end

    assign cs_q     = cs_sync[SYNC_STAGES-1];
    assign cs_rise  = cs_q & ~cs_prev;
    assign shift_en = ~cs_q;
`else
    logic unused_inputs;
    assign unused_inputs = CS ^ err_clr;
    assign shift_en      = 1'b1;
`endif

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_rdy;
    logic       byte_dc;
    logic [7:0] byte_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            byte_rdy  <= 1'b0;
            byte_dc   <= 1'b0;
            byte_data <= 8'd0;
        end else begin
            byte_rdy <= 1'b0;
            if (!shift_en) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], sdin_q};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_rdy  <= 1'b1;
                    byte_data <= {shreg, sdin_q};
                    byte_dc   <= dc_q;
                end
            end
        end
    end

    logic [1:0] state;
    logic [6:0] col;
    logic [1:0] page;
    logic [1:0] page_start;
    logic [1:0] page_end;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= CMD;
            col        <= 7'd0;
            page       <= 2'd0;
            page_start <= 2'd0;
            page_end   <= 2'd3;
            fb_we      <= 1'b0;
            fb_addr    <= 9'd0;
            fb_wdata   <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'd0;
            disp_on    <= 1'b0;
            entire_on  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (byte_rdy) begin
                if (byte_dc) begin
                    // A data byte always writes and abandons any pending argument.
                    fb_we      <= 1'b1;
                    fb_addr    <= {page, col};
                    fb_wdata   <= byte_data;
                    frame_done <= (col == 7'd127) && (page == page_end);
                    state      <= CMD;
                    if (col == 7'd127) begin
                        col  <= 7'd0;
                        page <= (page == page_end) ? page_start : page + 2'd1;
                    end else begin
                        col <= col + 7'd1;
                    end
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= byte_data;
                    case (state)
                        CMD: begin
                            case (byte_data)
                                8'hAE: disp_on   <= 1'b0;
                                8'hAF: disp_on   <= 1'b1;
                                8'hA4: entire_on <= 1'b0;
                                8'hA5: entire_on <= 1'b1;
                                8'h22: state     <= ARG_PS;
                                8'h81, 8'h8D, 8'hD9, 8'hDA,
                                8'hA8, 8'hD3, 8'hD5: state <= ARG_SKIP;
                                default: begin
                                    if (byte_data[7:4] == 4'h0)
                                        col[3:0] <= byte_data[3:0];
                                    else if (byte_data[7:3] == 5'b00010)
                                        col[6:4] <= byte_data[2:0];
                                end
                            endcase
                        end
                        ARG_PS: begin
                            page_start <= byte_data[1:0];
                            page       <= byte_data[1:0];
                            state      <= ARG_PE;
                        end
                        ARG_PE: begin
                            page_end <= byte_data[1:0];
                            state    <= CMD;
                        end
                        default: state <= CMD;
                    endcase
                end
            end
`ifdef OLED_SINK_CS_EN
            if (cs_q)
                state <= CMD;
`endif
        end
    end

`ifdef OLED_SINK_CS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            frame_err <= 1'b0;
        else if (cs_rise && (bit_cnt != 3'd0))
            frame_err <= 1'b1;
        else if (err_clr)
            frame_err <= 1'b0;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: directed and random byte streams against a behavioural display model.
`default_nettype none

module tb_oled_spi_sink;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sclk = 1'b1;
    logic       sdin = 1'b0;
    logic       dc = 1'b0;
    logic       cs = 1'b0;
    logic       err_clr = 1'b0;
    logic       fb_we;
    logic [8:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       disp_on;
    logic       entire_on;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    oled_spi_sink #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .SCLK(sclk), .SDIN(sdin), .DC(dc), .CS(cs),
        .err_clr(err_clr), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .disp_on(disp_on),
        .entire_on(entire_on), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Observed events, captured away from the active edge.
    logic [16:0] got_wr[$];
    bit          got_fd[$];
    logic [7:0]  got_cmd[$];
    int          got_fd_total = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (fb_we) begin
                got_wr.push_back({fb_addr, fb_wdata});
                got_fd.push_back(frame_done);
            end
            if (frame_done) got_fd_total++;
            if (cmd_valid) got_cmd.push_back(cmd_byte);
        end
    end

    // Behavioural display model: linear cursor inside a page window.
    logic [16:0] exp_wr[$];
    bit          exp_fd[$];
    logic [7:0]  exp_cmd[$];
    int          exp_fd_total = 0;
    int m_page, m_col, m_ps, m_pe, m_pend;
    bit m_disp, m_ent;

    task automatic model_reset();
        m_page = 0; m_col = 0; m_ps = 0; m_pe = 3; m_pend = 0;
        m_disp = 0; m_ent = 0;
    endtask

    task automatic model_byte(input bit is_data, input logic [7:0] b);
        int addr;
        if (is_data) begin
            addr = m_page * 128 + m_col;
            exp_wr.push_back({addr[8:0], b});
            exp_fd.push_back(m_col == 127 && m_page == m_pe);
            if (m_col == 127 && m_page == m_pe) exp_fd_total++;
            if (m_col == 127) begin
                m_col  = 0;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 4;
            end else begin
                m_col = m_col + 1;
            end
            m_pend = 0;
        end else begin
            exp_cmd.push_back(b);
            if (m_pend == 1) begin
                m_ps = b % 4; m_page = b % 4; m_pend = 2;
            end else if (m_pend == 2) begin
                m_pe = b % 4; m_pend = 0;
            end else if (m_pend == 3) begin
                m_pend = 0;
            end else if (b == 8'hAE) m_disp = 0;
            else if (b == 8'hAF) m_disp = 1;
            else if (b == 8'hA4) m_ent = 0;
            else if (b == 8'hA5) m_ent = 1;
            else if (b == 8'h22) m_pend = 1;
            else if (b inside {8'h81, 8'h8D, 8'hD9, 8'hDA, 8'hA8, 8'hD3, 8'hD5}) m_pend = 3;
            else if (b < 16) m_col = (m_col / 16) * 16 + b;
            else if (b < 24) m_col = (m_col % 16) + (b - 16) * 16;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input bit b, input bit d);
        sclk = 1'b0; sdin = b; dc = d;
        #40;
        sclk = 1'b1;
        #40;
    endtask

    task automatic send_byte(input bit is_data, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], is_data);
        model_byte(is_data, b);
    endtask

    task automatic clear_queues();
        got_wr.delete(); got_fd.delete(); got_cmd.delete();
        exp_wr.delete(); exp_fd.delete(); exp_cmd.delete();
        got_fd_total = 0; exp_fd_total = 0;
    endtask

    task automatic drain_check(input string tag);
        int n;
        #200;
        check({tag, " write count"}, got_wr.size(), exp_wr.size());
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s write %0d {addr,data}", tag, i), {15'd0, got_wr[i]}, {15'd0, exp_wr[i]});
            check($sformatf("%s frame_done at write %0d", tag, i), {31'd0, got_fd[i]}, {31'd0, exp_fd[i]});
        end
        check({tag, " frame_done total"}, got_fd_total, exp_fd_total);
        check({tag, " cmd count"}, got_cmd.size(), exp_cmd.size());
        n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s cmd %0d", tag, i), {24'd0, got_cmd[i]}, {24'd0, exp_cmd[i]});
        check({tag, " disp_on"}, {31'd0, disp_on}, {31'd0, m_disp});
        check({tag, " entire_on"}, {31'd0, entire_on}, {31'd0, m_ent});
        clear_queues();
    endtask

    logic [7:0] seq_cmds [13];
    logic [7:0] st_bytes [4];
    bit         st_disp  [4];
    bit         st_ent   [4];

    initial begin
        logic [7:0] b;
        model_reset();
        seq_cmds = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'h22, 8'h81, 8'h8D,
                     8'hD9, 8'hDA, 8'hA8, 8'hD3, 8'hD5, 8'h00};
        st_bytes = '{8'hAF, 8'hA5, 8'hA4, 8'hAE};
        st_disp  = '{1'b1, 1'b1, 1'b1, 1'b0};
        st_ent   = '{1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        #30;
        check("reset outputs",
              {1'b0, fb_we, fb_addr, fb_wdata, cmd_valid, cmd_byte, disp_on, entire_on, frame_done, frame_err},
              32'd0);
        rstn = 1'b1;
        #40;

        // Page command sequence
        send_byte(0, 8'h22); send_byte(0, 8'h01); send_byte(0, 8'h02);
        send_byte(0, 8'h00); send_byte(0, 8'h10); send_byte(1, 8'h5A);
        #200;
        check("page cmd write count", got_wr.size(), 1);
        if (got_wr.size() > 0) check("page cmd write", {15'd0, got_wr[0]}, {15'd0, 9'h080, 8'h5A});
        check("page cmd cmd_valid count", got_cmd.size(), 5);
        drain_check("page cmd");

        // State commands
        for (int i = 0; i < 4; i++) begin
            send_byte(0, st_bytes[i]);
            #200;
            check($sformatf("state %0h disp_on", st_bytes[i]), {31'd0, disp_on}, {31'd0, st_disp[i]});
            check($sformatf("state %0h entire_on", st_bytes[i]), {31'd0, entire_on}, {31'd0, st_ent[i]});
        end
        drain_check("state cmds");

        // Skipped argument swallows AF
        send_byte(0, 8'h81); send_byte(0, 8'hAF);
        #200;
        check("skip arg disp_on", {31'd0, disp_on}, 32'd0);
        send_byte(0, 8'hAF);
        #200;
        check("after skip disp_on", {31'd0, disp_on}, 32'd1);
        drain_check("skip arg");

        // Full frame with random data
        send_byte(0, 8'h22); send_byte(0, 8'h00); send_byte(0, 8'h03);
        send_byte(0, 8'h00); send_byte(0, 8'h10);
        for (int i = 0; i < 512; i++) send_byte(1, 8'($urandom));
        #200;
        check("full frame write count", got_wr.size(), 512);
        check("full frame done count", got_fd_total, 1);
        if (got_wr.size() == 512) begin
            check("full frame last addr", {23'd0, got_wr[511][16:8]}, 32'd511);
            check("full frame done on last", {31'd0, got_fd[511]}, 32'd1);
        end
        drain_check("full frame");
        send_byte(1, 8'hE7);
        #200;
        if (got_wr.size() > 0) check("wrap addr", {23'd0, got_wr[0][16:8]}, 32'd0);
        drain_check("frame wrap");

        // Random command/data mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    send_byte(1, 8'($urandom));
                2:       send_byte(0, 8'($urandom_range(0, 23)));
                3:       send_byte(0, 8'($urandom));
                default: begin
                    b = seq_cmds[$urandom_range(0, 12)];
                    send_byte(0, b);
                end
            endcase
        end
        drain_check("random");

`ifdef OLED_SINK_CS_EN
        // Aborted byte under chip select
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        cs = 1'b1;
        m_pend = 0;
        #200;
        check("abort frame_err", {31'd0, frame_err}, 32'd1);
        cs = 1'b0;
        #40;
        send_byte(0, 8'hA5);
        drain_check("after abort");
        err_clr = 1'b1;
        #10;
        err_clr = 1'b0;
        #20;
        check("err_clr frame_err", {31'd0, frame_err}, 32'd0);
`endif

        // Reset in the middle of a byte
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        rstn = 1'b0;
        #20;
        check("mid-byte reset outputs",
              {1'b0, fb_we, fb_addr, fb_wdata, cmd_valid, cmd_byte, disp_on, entire_on, frame_done, frame_err},
              32'd0);
        clear_queues();
        model_reset();
        rstn = 1'b1;
        #40;
        send_byte(1, 8'hC3);
        #200;
        check("post reset write count", got_wr.size(), 1);
        if (got_wr.size() > 0) check("post reset write", {15'd0, got_wr[0]}, {15'd0, 9'h000, 8'hC3});
        drain_check("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oled_spi_sink.md
# oled_spi_sink

Receive side of the OLED SPI link: a cycle-accurate SSD1306-subset responder that deserialises SCLK/SDIN/DC/CS from the display controller. It decodes display commands and writes data bytes into a 512-byte pixel framebuffer (4 pages × 128 columns) through a write port. It is used as the display model in system benches and as the capture front end for mirroring the OLED image to another output.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on SCLK, SDIN, DC and CS. Legal values are 2 or 3.

Ports:
- `clk` input 1: system clock. SCLK must be at most clk/8.
- `rstn` input 1: asynchronous, active-low reset.
- `SCLK` input 1: SPI clock. Idles high; SDIN is sampled on its rising edge, MSB first.
- `SDIN` input 1: serial data.
- `DC` input 1: 0 = command byte, 1 = data byte. Sampled together with bit 0 of each byte.
- `CS` input 1: active-low chip select. Used only with `OLED_SINK_CS_EN`.
- `err_clr` input 1: clears `frame_err`.
- `fb_we` output 1: framebuffer write strobe. One-cycle pulse.
- `fb_addr` output 9: framebuffer address {page[1:0], col[6:0]}.
- `fb_wdata` output 8: framebuffer write data.
- `cmd_valid` output 1: one-cycle pulse on each received command or argument byte.
- `cmd_byte` output 8: the received command or argument byte.
- `disp_on` output 1: display on state.
- `entire_on` output 1: entire-display-on state (A5 command active).
- `frame_done` output 1: one-cycle pulse when the last byte of a frame window is written.
- `frame_err` output 1: sticky flag for an aborted partial byte.

## Operation
**Reset values:**
- All outputs are 0.
- `col` = 0, `page` = 0, `page_start` = 0, `page_end` = 3.
- Bit counter = 0; FSM is in `CMD`.

**Deserialiser:**
- Synchronised rising edge of SCLK shifts SDIN into an 8-bit shift register.
- On the 8th bit a byte is complete, tagged with the synchronised DC value at that edge.
- The bit counter then wraps to 0.

**Decoder FSM** (states `CMD`, `ARG_PS`, `ARG_PE`, `ARG_SKIP`). In every state a data byte (DC = 1) performs a data write; if the FSM is not in `CMD`, the pending argument is abandoned and the FSM returns to `CMD`.
- In `CMD`:
  - AE clears `disp_on`; AF sets it.
  - A4 clears `entire_on`; A5 sets it.
  - 00–0F: `col[3:0]` = byte[3:0].
  - 10–17: `col[6:4]` = byte[2:0].
  - 22: go to `ARG_PS`.
  - 81, 8D, D9, DA, A8, D3, D5: go to `ARG_SKIP`.
  - All other bytes are ignored and the FSM stays in `CMD`.
- `ARG_PS`: `page_start` = byte[1:0], `page` = byte[1:0]; go to `ARG_PE`.
- `ARG_PE`: `page_end` = byte[1:0]; go to `CMD`.
- `ARG_SKIP`: discard the byte; go to `CMD`.
- `cmd_valid`/`cmd_byte` report every DC = 0 byte, including argument bytes.

**Data write:**
- `fb_addr` = {page, col}, `fb_wdata` = byte, `fb_we` pulses.
- Then `col` increments. At 127, `col` wraps to 0 and `page` advances: if `page == page_end` it reloads `page_start`, otherwise it increments, wrapping 3→0.
- `frame_done` pulses in the same cycle as the write at `col` = 127, `page` = `page_end`.
- Data writes are accepted regardless of `disp_on`.

**Errors:**
- `frame_err` is set on CS deassertion with a nonzero bit count (CS_EN builds only).
- It is cleared by `err_clr`; if set and clear occur in the same cycle, set wins.

## Timing
- **Latency:** `fb_we` / `cmd_valid` rise on the 3rd clk edge after the edge at which the first synchroniser stage captures the 8th SCLK rising level (`SYNC_STAGES` = 2); add 1 cycle per extra stage.
- **State updates:** `disp_on`, `entire_on`, `col` and `page` update on that same edge.
- **Throughput:** one byte per 8 SCLK periods. There is no backpressure; the framebuffer port must accept a write every cycle.
- **Reset mid-byte:** the partial byte is discarded and nothing is written.
- **Back-to-back bytes:** no gap is required, because SCLK is at most clk/8.

## Configuration
- `OLED_SINK_CS_EN` defined:
  - CS high holds the bit counter at 0, ignores SCLK edges, and returns the FSM to `CMD`.
  - A CS rising edge with a nonzero bit count sets `frame_err`.
- `OLED_SINK_CS_EN` undefined:
  - CS is ignored.
  - Framing relies solely on the free-running bit counter, which is cleared only by `rstn`.
  - `frame_err` is tied to 0.

## Test plan
- **Page command:** reset, then send cmd 22, 01, 02, 00, 10, then data 5A → one `fb_we` with `fb_addr` = 0x080, `fb_wdata` = 5A; `cmd_valid` pulses 5 times.
- **Full frame:** send cmd 22, 00, 03, then 512 data bytes of value i&FF → `fb_addr` runs 0..511 in order, one `frame_done` on the 512th write, next write goes to `fb_addr` 0.
- **State commands:** send AF, A5, A4, AE → `disp_on`/`entire_on` go 1/0, 1/1, 1/0, 0/0; no `fb_we`.
- **Skipped argument:** send cmd 81 then cmd AF → AF is consumed as an argument and `disp_on` stays 0; a following AF sets `disp_on` = 1.
- **Aborted byte (CS_EN):** raise CS after 5 bits → no write, `frame_err` = 1; the next full byte A5 decodes correctly; `err_clr` gives `frame_err` = 0.
- **Reset mid-byte:** assert `rstn` low after 3 bits → all outputs 0; a following 8-bit data byte C3 writes to `fb_addr` 0.
